// File: rtl/fc_pkg.sv
// Shared constants, command field positions and FSM state encoding for the
// flash-controller command scheduler.
package fc_pkg;

  localparam int CMD_W      = 33;
  localparam int CMD_RD_BIT = 32;
  localparam int FLASH_MSB  = 31;
  localparam int FLASH_LSB  = 14;
  localparam int SRAM_MSB   = 13;
  localparam int SRAM_LSB   = 7;
  localparam int LEN_MSB    = 6;
  localparam int LEN_LSB    = 0;
  localparam int SRAM_WORDS = 128;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    CPL
  } state_t;

  // A transfer running past the end of SRAM is rejected; the sum is 8 bits wide
  // so two 7-bit fields can never wrap.
  function automatic logic sram_overrun(input logic [6:0] sram, input logic [6:0] len);
    logic [7:0] sum;
    sum = {1'b0, sram} + {1'b0, len};
    return sum > 8'(SRAM_WORDS);
  endfunction

endpackage

// File: rtl/fc_cmd_fifo.sv
// Small synchronous FIFO holding queued commands for one requester.
module fc_cmd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fc_cmd_sched.sv
// Two-requester command scheduler: per-requester FIFOs, round-robin arbiter,
// range check and the issue/complete handshake towards the flash controller.
module fc_cmd_sched
  import fc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_TO    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [32:0] r0_cmd,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [32:0] r1_cmd,
  output logic        r1_ready,
  output logic [32:0] fc_cmd,
  output logic        fc_cmd_valid,
  input  logic        fc_done,
  output logic        cpl_valid,
  output logic        cpl_id,
  output logic        cpl_err,
  output logic [32:0] cpl_cmd,
  output logic        busy
);

  localparam int TW = $clog2(BUSY_TO + 1);

  state_t          state;
  logic            last_id;
  logic [TW-1:0]   to_cnt;

  logic            f0_full, f0_empty, f1_full, f1_empty;
  logic [32:0]     f0_head, f1_head;
  logic            pop0, pop1;

  logic            grant_valid;
  logic            grant_id;
  logic [32:0]     grant_cmd;
  logic            grant_zero;
  logic            grant_bad;

  fc_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (r0_valid),
    .wdata (r0_cmd),
    .pop   (pop0),
    .rdata (f0_head),
    .full  (f0_full),
    .empty (f0_empty)
  );

  fc_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (r1_valid),
    .wdata (r1_cmd),
    .pop   (pop1),
    .rdata (f1_head),
    .full  (f1_full),
    .empty (f1_empty)
  );

  assign r0_ready = ~f0_full;
  assign r1_ready = ~f1_full;

  // Round-robin between two heads; a lone non-empty FIFO always wins.
  always_comb begin
    grant_valid = ~f0_empty | ~f1_empty;
    grant_id    = f0_empty;
    if (!f0_empty && !f1_empty) grant_id = ~last_id;
    grant_cmd   = grant_id ? f1_head : f0_head;
    grant_zero  = (grant_cmd[LEN_MSB:LEN_LSB] == '0);
    grant_bad   = sram_overrun(grant_cmd[SRAM_MSB:SRAM_LSB], grant_cmd[LEN_MSB:LEN_LSB]);
  end

  assign pop0 = (state == ARB) & grant_valid & ~grant_id;
  assign pop1 = (state == ARB) & grant_valid &  grant_id;
  assign busy = grant_valid | (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_id      <= 1'b1;
      to_cnt       <= '0;
      fc_cmd       <= '0;
      fc_cmd_valid <= 1'b0;
      cpl_valid    <= 1'b0;
      cpl_id       <= 1'b0;
      cpl_err      <= 1'b0;
      cpl_cmd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) state <= ARB;
        end
        ARB: begin
          if (grant_valid) begin
            fc_cmd  <= grant_cmd;
            cpl_cmd <= grant_cmd;
            cpl_id  <= grant_id;
            last_id <= grant_id;
            cpl_err <= 1'b0;
            if (grant_zero) begin
              cpl_valid <= 1'b1;
              state     <= CPL;
            end else if (grant_bad) begin
              cpl_err   <= 1'b1;
              cpl_valid <= 1'b1;
              state     <= CPL;
            end else begin
              fc_cmd_valid <= 1'b1;
              state        <= ISSUE;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (fc_done) begin
            fc_cmd_valid <= 1'b0;
            to_cnt       <= '0;
            state        <= WAIT_BUSY;
          end
        end
        // FC must acknowledge by dropping done; if it never does, give up.
        WAIT_BUSY: begin
          if (!fc_done) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TW'(BUSY_TO - 1)) begin
            cpl_err   <= 1'b1;
            cpl_valid <= 1'b1;
            state     <= CPL;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (fc_done) begin
            cpl_valid <= 1'b1;
            state     <= CPL;
          end
        end
        CPL: begin
          cpl_valid <= 1'b0;
          state     <= grant_valid ? ARB : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_cmd_sched.sv
// Self-checking bench for fc_cmd_sched: directed scenarios plus random batches
// scored against a transaction-level model of arbitration and completion rules.
module tb_fc_cmd_sched;

  localparam int FIFO_DEPTH = 4;
  localparam int BUSY_TO    = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic [32:0] r0_cmd, r1_cmd;
  logic        r0_ready, r1_ready;
  logic [32:0] fc_cmd;
  logic        fc_cmd_valid;
  logic        fc_done;
  logic        cpl_valid, cpl_id, cpl_err;
  logic [32:0] cpl_cmd;
  logic        busy;

  typedef struct {
    logic        id;
    logic        err;
    logic        tmo;
    logic [32:0] cmd;
  } cpl_t;

  cpl_t        expQ[$];
  logic [32:0] issQ[$];
  logic [32:0] m0[$];
  logic [32:0] m1[$];
  logic        lastId = 1'b1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lastIssueCyc = 0;
  logic monOn = 1'b0;
  logic fcHold = 1'b0;
  int   fcDropFix = 0;
  int   fcBusyFix = 0;
  cpl_t monE;

  fc_cmd_sched #(.FIFO_DEPTH(FIFO_DEPTH), .BUSY_TO(BUSY_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .r0_valid     (r0_valid),
    .r0_cmd       (r0_cmd),
    .r0_ready     (r0_ready),
    .r1_valid     (r1_valid),
    .r1_cmd       (r1_cmd),
    .r1_ready     (r1_ready),
    .fc_cmd       (fc_cmd),
    .fc_cmd_valid (fc_cmd_valid),
    .fc_done      (fc_done),
    .cpl_valid    (cpl_valid),
    .cpl_id       (cpl_id),
    .cpl_err      (cpl_err),
    .cpl_cmd      (cpl_cmd),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic rangeErr(input logic [32:0] c);
    int s;
    int l;
    s = int'(c[13:7]);
    l = int'(c[6:0]);
    return (l != 0) && (s + l > 128);
  endfunction

  // Bench rule: the FC model never acknowledges commands whose flash address ends in 2'b11.
  function automatic logic isTimeout(input logic [32:0] c);
    return c[15:14] == 2'b11;
  endfunction

  function automatic logic [32:0] mkCmd(input logic rd, input logic [17:0] fl,
                                        input logic [6:0] sram, input logic [6:0] len);
    return {rd, fl, sram, len};
  endfunction

  function automatic logic [32:0] randCmd();
    logic [17:0] fl;
    logic [6:0]  sram;
    logic [6:0]  len;
    int          sel;
    fl   = 18'($urandom);
    sram = 7'($urandom);
    len  = 7'($urandom_range(1, 40));
    sel  = $urandom_range(0, 7);
    if (sel == 0) len = 7'd0;
    else if (sel == 1) begin
      sram = 7'($urandom_range(96, 127));
      len  = 7'($urandom_range(1, 60));
    end
    return mkCmd(1'($urandom), fl, sram, len);
  endfunction

  // FC model: done is high while idle, drops a few cycles after accepting, then rises.
  initial begin
    logic        hsNow;
    logic [32:0] cmdNow;
    logic        active;
    int          dropCnt;
    int          riseCnt;
    active  = 1'b0;
    dropCnt = 0;
    riseCnt = 0;
    fc_done = 1'b1;
    forever begin
      @(negedge clk);
      hsNow  = fc_cmd_valid && fc_done;
      cmdNow = fc_cmd;
      @(posedge clk);
      #1;
      if (!rst) begin
        fc_done = 1'b1;
        active  = 1'b0;
      end else if (hsNow) begin
        if (!isTimeout(cmdNow)) begin
          active  = 1'b1;
          dropCnt = (fcDropFix != 0) ? fcDropFix : $urandom_range(1, 6);
          riseCnt = (fcBusyFix != 0) ? fcBusyFix : $urandom_range(1, 20);
        end
      end else if (active) begin
        if (dropCnt > 0) begin
          dropCnt--;
          if (dropCnt == 0) fc_done = 1'b0;
        end else if (!fcHold) begin
          riseCnt--;
          if (riseCnt <= 0) begin
            fc_done = 1'b1;
            active  = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard: every issue and completion is matched against the model queues.
  always @(negedge clk) begin
    if (monOn && rst) begin
      if (fc_cmd_valid && fc_done) begin
        if (issQ.size() == 0) checkOutput("issue_pending", 33'(issQ.size()), 33'd1);
        else begin
          checkOutput("issue_cmd", fc_cmd, issQ.pop_front());
          lastIssueCyc = cyc + 1;
        end
      end
      if (cpl_valid) begin
        if (expQ.size() == 0) checkOutput("cpl_pending", 33'(expQ.size()), 33'd1);
        else begin
          monE = expQ.pop_front();
          checkOutput("cpl_id", 33'(cpl_id), 33'(monE.id));
          checkOutput("cpl_err", 33'(cpl_err), 33'(monE.err));
          checkOutput("cpl_cmd", cpl_cmd, monE.cmd);
          if (monE.tmo) checkOutput("tmo_latency", 33'(cyc - lastIssueCyc), 33'(BUSY_TO));
        end
      end
    end
  end

  // Batches push both requesters from the same edge, at most FIFO_DEPTH each, so the
  // first arbitration sees both heads and later ones see the whole batch.
  task automatic applyStimulus();
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] c;
    logic        id;
    cpl_t        e;
    int          n;
    q0 = m0;
    q1 = m1;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) id = (lastId == 1'b1) ? 1'b0 : 1'b1;
      else id = (m0.size() > 0) ? 1'b0 : 1'b1;
      if (id) c = m1.pop_front();
      else c = m0.pop_front();
      lastId = id;
      e.id  = id;
      e.cmd = c;
      e.tmo = (c[6:0] != 0) && !rangeErr(c) && isTimeout(c);
      e.err = rangeErr(c) || e.tmo;
      expQ.push_back(e);
      if (c[6:0] != 0 && !rangeErr(c)) issQ.push_back(c);
    end
    n = (q0.size() > q1.size()) ? q0.size() : q1.size();
    for (int k = 0; k < n; k++) begin
      r0_valid = (k < q0.size());
      r1_valid = (k < q1.size());
      if (k < q0.size()) begin
        r0_cmd = q0[k];
        checkOutput("r0_ready", 33'(r0_ready), 33'd1);
      end
      if (k < q1.size()) begin
        r1_cmd = q1[k];
        checkOutput("r1_ready", 33'(r1_ready), 33'd1);
      end
      @(negedge clk);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 33'(n >= limit), 33'd0);
    checkOutput("issue_left", 33'(issQ.size()), 33'd0);
  endtask

  task automatic applyReset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expQ.delete();
    issQ.delete();
    lastId = 1'b1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_fc_valid"}, 33'(fc_cmd_valid), 33'd0);
    checkOutput({tag, "_fc_cmd"}, fc_cmd, 33'd0);
    checkOutput({tag, "_cpl_valid"}, 33'(cpl_valid), 33'd0);
    checkOutput({tag, "_cpl_id"}, 33'(cpl_id), 33'd0);
    checkOutput({tag, "_cpl_err"}, 33'(cpl_err), 33'd0);
    checkOutput({tag, "_cpl_cmd"}, cpl_cmd, 33'd0);
    checkOutput({tag, "_busy"}, 33'(busy), 33'd0);
    checkOutput({tag, "_r0_ready"}, 33'(r0_ready), 33'd1);
    checkOutput({tag, "_r1_ready"}, 33'(r1_ready), 33'd1);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cplSeen;
    int c0;
    int c1;
    logic [32:0] cmd;

    rst = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    r0_cmd = '0;
    r1_cmd = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    @(negedge clk);
    monOn = 1'b1;

    // Single read with fixed FC timing and latency checks around the issue.
    fcDropFix = 2;
    fcBusyFix = 40;
    cmd = mkCmd(1'b1, 18'h00010, 7'h00, 7'd16);
    m0.push_back(cmd);
    applyStimulus();
    @(negedge clk);
    checkOutput("read_arb_valid", 33'(fc_cmd_valid), 33'd0);
    checkOutput("read_arb_busy", 33'(busy), 33'd1);
    @(negedge clk);
    checkOutput("read_issue_valid", 33'(fc_cmd_valid), 33'd1);
    checkOutput("read_issue_cmd", fc_cmd, cmd);
    waitIdle(200);
    fcDropFix = 0;
    fcBusyFix = 0;

    // Contention: round-robin starting from requester 0 after reset.
    applyReset();
    for (int i = 0; i < 3; i++) begin
      m0.push_back(mkCmd(1'b0, 18'h00100 + 18'(i * 4), 7'(i * 8), 7'd4));
      m1.push_back(mkCmd(1'b1, 18'h00200 + 18'(i * 4), 7'(i * 8 + 1), 7'd5));
    end
    applyStimulus();
    waitIdle(600);

    // Range error: never issued, completes two cycles after the push edge.
    cmd = mkCmd(1'b0, 18'h00100, 7'h7C, 7'd8);
    m1.push_back(cmd);
    applyStimulus();
    @(negedge clk);
    checkOutput("range_arb_cpl", 33'(cpl_valid), 33'd0);
    @(negedge clk);
    checkOutput("range_cpl_valid", 33'(cpl_valid), 33'd1);
    checkOutput("range_cpl_err", 33'(cpl_err), 33'd1);
    checkOutput("range_fc_valid", 33'(fc_cmd_valid), 33'd0);
    waitIdle(50);

    // Exactly filling SRAM is legal.
    m0.push_back(mkCmd(1'b0, 18'h00002, 7'h78, 7'd8));
    applyStimulus();
    waitIdle(200);

    // Zero length completes without issue and without error.
    m0.push_back(mkCmd(1'b1, 18'h00030, 7'h10, 7'd0));
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    checkOutput("zero_cpl_valid", 33'(cpl_valid), 33'd1);
    checkOutput("zero_cpl_err", 33'(cpl_err), 33'd0);
    waitIdle(50);

    // Timeout: FC never drops done.
    m0.push_back(mkCmd(1'b1, 18'h00013, 7'h10, 7'd4));
    applyStimulus();
    waitIdle(200);

    // Backpressure with FC stalled in a long operation, then reset mid-flight.
    monOn = 1'b0;
    fcHold = 1'b1;
    fcDropFix = 2;
    fcBusyFix = 5;
    r0_valid = 1'b1;
    r0_cmd = mkCmd(1'b1, 18'h00020, 7'h00, 7'd8);
    @(negedge clk);
    r0_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("stall_busy", 33'(busy), 33'd1);
    checkOutput("stall_fc_valid", 33'(fc_cmd_valid), 33'd0);
    for (int i = 0; i < 5; i++) begin
      r0_valid = 1'b1;
      r0_cmd = mkCmd(1'b0, 18'(i * 4), 7'(i), 7'd2);
      @(negedge clk);
      if (i == 2) checkOutput("bp_ready_after3", 33'(r0_ready), 33'd1);
      if (i == 3) checkOutput("bp_ready_after4", 33'(r0_ready), 33'd0);
    end
    r0_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    fcHold = 1'b0;
    fcDropFix = 0;
    fcBusyFix = 0;
    expQ.delete();
    issQ.delete();
    lastId = 1'b1;
    cplSeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpl_valid) cplSeen++;
    end
    checkOutput("post_reset_cpl", 33'(cplSeen), 33'd0);
    checkOutput("post_reset_busy", 33'(busy), 33'd0);
    monOn = 1'b1;

    // Random batches across both requesters.
    for (int b = 0; b < 25; b++) begin
      c0 = $urandom_range(0, FIFO_DEPTH);
      c1 = $urandom_range(0, FIFO_DEPTH);
      if (c0 == 0 && c1 == 0) c0 = 1;
      for (int i = 0; i < c0; i++) m0.push_back(randCmd());
      for (int i = 0; i < c1; i++) m1.push_back(randCmd());
      applyStimulus();
      waitIdle(3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
